// File: rtl/rfg_spi_pkg.sv
// ----------------------------------------------------------------------------
// rfg_spi_pkg
// Shared types and constants for the register-file SPI slave I/O port.
//   spi_state_t       : serial-side FSM state (encoding is exported on debug_state)
//   SPI_BITS          : bits per SPI byte
//   IDLE_BYTE_DEFAULT : byte shifted out on MISO when no readback is queued
// ----------------------------------------------------------------------------
package rfg_spi_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1
    } spi_state_t;

    localparam int unsigned SPI_BITS = 8;

    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

endpackage

// File: rtl/rfg_axis_spi_sync_fifo.sv
// ----------------------------------------------------------------------------
// rfg_axis_spi_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always present
// on rd_data_o (read straight from the register array) while empty_o is low.
// Pushes while full and pops while empty are ignored.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset (empties FIFO)
//   push_i, wr_data_i  : write strobe and data
//   pop_i              : advance past the current head
//   rd_data_o          : current head entry
//   full_o, empty_o    : occupancy flags
// ----------------------------------------------------------------------------
module rfg_axis_spi_sync_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];

    // One extra pointer bit distinguishes full from empty.
    logic [AddrW:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW:0] rd_ptr_q, rd_ptr_d;
    logic           push_ok;
    logic           pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign rd_data_o = mem_q[rd_ptr_q[AddrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/rfg_axis_spi_io.sv
// ----------------------------------------------------------------------------
// rfg_axis_spi_io
// SPI slave (mode 0, MSB first) bridging board pins to the AXIS register-file
// fabric. SCK/CSN/MOSI are oversampled in aclk (aclk >= 8x SCK).
//   MOSI bytes -> m_axis (tid = PORT_ID, tlast = 0), one-entry output register.
//   s_axis bytes with tdest == PORT_ID -> TX FIFO -> MISO; others are sunk.
// Ports:
//   aclk, aresetn                 : system clock, async active-low reset
//   spi_csn/clk/mosi              : SPI pins (asynchronous to aclk)
//   spi_miso, spi_miso_oe         : MISO data and tristate enable
//   m_axis_*                      : received bytes
//   s_axis_*                      : readback bytes (tlast ignored)
//   rx_overflow, rx_overflow_clear: sticky dropped-byte flag and its clear
//   debug_state                   : current FSM state (0 idle, 1 active)
// ----------------------------------------------------------------------------
module rfg_axis_spi_io
    import rfg_spi_pkg::*;
#(
    parameter int unsigned             ID_DEST_WIDTH = 8,
    parameter logic [ID_DEST_WIDTH-1:0] PORT_ID       = '0,
    parameter int unsigned             TX_FIFO_DEPTH = 16,
    parameter logic [7:0]              IDLE_BYTE     = IDLE_BYTE_DEFAULT
) (
    input  logic                     aclk,
    input  logic                     aresetn,

    input  logic                     spi_csn,
    input  logic                     spi_clk,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic                     spi_miso_oe,

    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [ID_DEST_WIDTH-1:0] m_axis_tid,
    output logic                     m_axis_tlast,

    input  logic [7:0]               s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [ID_DEST_WIDTH-1:0] s_axis_tdest,
    input  logic                     s_axis_tlast,

    output logic                     rx_overflow,
    input  logic                     rx_overflow_clear,
    output logic [1:0]               debug_state
);

    localparam int unsigned CntW = $clog2(SPI_BITS);

    // ------------------------------------------------------------------
    // Reset: asserted asynchronously, released on an aclk edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Pin synchronizers: [0],[1] metastability stages, [2] edge history.
    // CSN resets high so leaving reset never fakes a select edge.
    // MOSI is only sampled, never edge-detected, so it has no history flop.
    // ------------------------------------------------------------------
    logic [2:0] csn_sync_q;
    logic [2:0] sck_sync_q;
    logic [1:0] mosi_sync_q;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            csn_sync_q  <= 3'b111;
            sck_sync_q  <= 3'b000;
            mosi_sync_q <= 2'b00;
        end else begin
            csn_sync_q  <= {csn_sync_q[1:0], spi_csn};
            sck_sync_q  <= {sck_sync_q[1:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
        end
    end

    logic csn_fall, csn_rise, sck_rise, sck_fall, mosi_s;

    assign csn_fall = !csn_sync_q[1] &&  csn_sync_q[2];
    assign csn_rise =  csn_sync_q[1] && !csn_sync_q[2];
    assign sck_rise =  sck_sync_q[1] && !sck_sync_q[2];
    assign sck_fall = !sck_sync_q[1] &&  sck_sync_q[2];
    assign mosi_s   =  mosi_sync_q[1];

    // ------------------------------------------------------------------
    // TX FIFO (readback bytes for MISO)
    // ------------------------------------------------------------------
    logic       dest_match;
    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_rd_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] tx_next;

    assign dest_match    = (s_axis_tdest == PORT_ID);
    // Foreign-destination bytes are always accepted and dropped.
    assign s_axis_tready = rst_n && (!dest_match || !fifo_full);
    assign fifo_push     = s_axis_tvalid && s_axis_tready && dest_match;
    assign tx_next       = fifo_empty ? IDLE_BYTE : fifo_rd_data;

    rfg_axis_spi_sync_fifo #(
        .Depth (TX_FIFO_DEPTH),
        .Width (8)
    ) u_tx_fifo (
        .clk_i     (aclk),
        .rst_ni    (rst_n),
        .push_i    (fifo_push),
        .wr_data_i (s_axis_tdata),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    // ------------------------------------------------------------------
    // Serial FSM and datapath
    // ------------------------------------------------------------------
    spi_state_t      state_q, state_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    // Set at select; the first SCK fall then never reloads the TX byte.
    logic            first_fall_q, first_fall_d;
    logic [7:0]      tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic            ovf_q, ovf_d;

    always_comb begin
        state_d      = state_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        first_fall_d = first_fall_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        ovf_d        = ovf_q;
        fifo_pop     = 1'b0;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        if (rx_overflow_clear) begin
            ovf_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (csn_fall) begin
                    state_d      = StActive;
                    tx_shift_d   = tx_next;
                    fifo_pop     = !fifo_empty;
                    bit_cnt_d    = '0;
                    first_fall_d = 1'b1;
                end
            end

            StActive: begin
                // Deselect wins over any SCK edge seen in the same cycle.
                if (csn_rise) begin
                    state_d    = StIdle;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CntW'(SPI_BITS - 1)) begin
                        if (!tvalid_q || m_axis_tready) begin
                            tdata_d  = {rx_shift_q[6:0], mosi_s};
                            tvalid_d = 1'b1;
                        end else begin
                            // Set after the clear above, so set wins.
                            ovf_d = 1'b1;
                        end
                    end
                end else if (sck_fall) begin
                    first_fall_d = 1'b0;
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else if (!first_fall_q) begin
                        tx_shift_d = tx_next;
                        fifo_pop   = !fifo_empty;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            bit_cnt_q    <= '0;
            first_fall_q <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            first_fall_q <= first_fall_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            ovf_q        <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign spi_miso_oe   = (state_q == StActive);
    assign spi_miso      = spi_miso_oe && tx_shift_q[7];
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tid    = PORT_ID;
    assign m_axis_tlast  = 1'b0;
    assign rx_overflow   = ovf_q;
    assign debug_state   = state_q;

endmodule

// File: tb/tb_rfg_axis_spi_io.sv
module tb_rfg_axis_spi_io;

    localparam logic [7:0] PortId = 8'h05;
    localparam logic [7:0] IdleB  = 8'h00;

    logic       aclk;
    logic       aresetn;
    logic       spi_csn, spi_clk, spi_mosi, spi_miso, spi_miso_oe;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [7:0] m_axis_tid;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [7:0] s_axis_tdest;
    logic       rx_overflow, rx_overflow_clear;
    logic [1:0] debug_state;

    rfg_axis_spi_io #(
        .ID_DEST_WIDTH (8),
        .PORT_ID       (PortId),
        .TX_FIFO_DEPTH (16),
        .IDLE_BYTE     (IdleB)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .spi_csn           (spi_csn),
        .spi_clk           (spi_clk),
        .spi_mosi          (spi_mosi),
        .spi_miso          (spi_miso),
        .spi_miso_oe       (spi_miso_oe),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tid        (m_axis_tid),
        .m_axis_tlast      (m_axis_tlast),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tdest      (s_axis_tdest),
        .s_axis_tlast      (s_axis_tlast),
        .rx_overflow       (rx_overflow),
        .rx_overflow_clear (rx_overflow_clear),
        .debug_state       (debug_state)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: TX FIFO contents and AXIS beat scoreboard.
    logic [7:0] tx_model[$];
    logic [7:0] exp_beats[$];
    logic [7:0] got_beats[$];

    function automatic logic [7:0] model_next();
        if (tx_model.size() > 0) return tx_model.pop_front();
        return IdleB;
    endfunction

    // m_axis monitor, sampled mid-cycle.
    logic       stall_q = 1'b0;
    logic [7:0] stall_data = 8'h00;
    always @(negedge aclk) begin
        #2;
        if (!aresetn) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check_eq("tvalid_hold", m_axis_tvalid, 1);
                check_eq("tdata_hold", m_axis_tdata, stall_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_beats.push_back(m_axis_tdata);
                check_eq("tid", m_axis_tid, PortId);
                check_eq("tlast", m_axis_tlast, 0);
            end
            stall_q    = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
        end
    end

    task automatic axis_push(input logic [7:0] d, input logic [7:0] dest);
        logic ok;
        ok = 1'b0;
        @(negedge aclk);
        s_axis_tdata  = d;
        s_axis_tdest  = dest;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            #2;
            ok = s_axis_tready;
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        check_eq("push_accept", ok, 1);
        if (ok && dest == PortId) tx_model.push_back(d);
    endtask

    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = mo[i];
            #50;
            mi[i]   = spi_miso;
            spi_clk = 1'b1;
            #50;
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input int n, input bit expect_beats);
        logic [7:0] bytes [4];
        logic [7:0] mi, exp_miso;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        @(negedge aclk);
        spi_csn = 1'b0;
        #80;
        exp_miso = model_next();
        for (int k = 0; k < n; k++) begin
            spi_byte(bytes[k], mi);
            check_eq("miso_byte", mi, exp_miso);
            if (k == 0) begin
                check_eq("miso_oe_active", spi_miso_oe, 1);
                check_eq("state_active", debug_state, 1);
            end
            if (expect_beats) exp_beats.push_back(bytes[k]);
            // Every byte-boundary SCK fall pops, including after the last byte.
            exp_miso = model_next();
        end
        #50;
        spi_csn = 1'b1;
        #100;
        check_eq("miso_oe_idle", spi_miso_oe, 0);
        check_eq("miso_idle", spi_miso, 0);
        check_eq("state_idle", debug_state, 0);
    endtask

    task automatic compare_beats();
        repeat (10) @(negedge aclk);
        check_eq("beat_count", got_beats.size(), exp_beats.size());
        while (got_beats.size() > 0 && exp_beats.size() > 0) begin
            check_eq("beat_data", got_beats.pop_front(), exp_beats.pop_front());
        end
        got_beats.delete();
        exp_beats.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tvalid"}, m_axis_tvalid, 0);
        check_eq({tag, "_tdata"}, m_axis_tdata, 0);
        check_eq({tag, "_miso"}, spi_miso, 0);
        check_eq({tag, "_miso_oe"}, spi_miso_oe, 0);
        check_eq({tag, "_overflow"}, rx_overflow, 0);
        check_eq({tag, "_s_tready"}, s_axis_tready, 0);
        check_eq({tag, "_state"}, debug_state, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] r [4];
        logic [7:0] mi;
        int         nb, np;
        aresetn = 1'b0;
        spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tdest = '0; s_axis_tlast = 1'b0;
        rx_overflow_clear = 1'b0;

        repeat (3) @(negedge aclk);
        #2;
        check_reset_outputs("reset");
        check_eq("tid_const", m_axis_tid, PortId);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);

        // Two received beats, idle MISO.
        spi_frame(8'hA5, 8'h3C, 8'h00, 8'h00, 2, 1'b1);
        compare_beats();
        check_eq("overflow_clean", rx_overflow, 0);

        // Readback ordering then idle byte.
        axis_push(8'h81, PortId);
        axis_push(8'h7E, PortId);
        spi_frame(8'h01, 8'h02, 8'h03, 8'h00, 3, 1'b1);
        compare_beats();

        // Foreign destination is sunk.
        axis_push(8'h55, PortId + 8'd1);
        spi_frame(8'h44, 8'h00, 8'h00, 8'h00, 1, 1'b1);
        compare_beats();

        // Overflow with downstream stalled.
        @(negedge aclk);
        m_axis_tready = 1'b0;
        spi_frame(8'h11, 8'h22, 8'h00, 8'h00, 2, 1'b0);
        #2;
        check_eq("ovf_tdata", m_axis_tdata, 8'h11);
        check_eq("ovf_tvalid", m_axis_tvalid, 1);
        check_eq("ovf_flag", rx_overflow, 1);
        @(negedge aclk);
        rx_overflow_clear = 1'b1;
        @(negedge aclk);
        rx_overflow_clear = 1'b0;
        #2;
        check_eq("ovf_cleared", rx_overflow, 0);
        @(negedge aclk);
        m_axis_tready = 1'b1;
        exp_beats.push_back(8'h11);
        compare_beats();

        // Fill the FIFO; the 17th byte must be back-pressured.
        for (int i = 0; i < 16; i++) axis_push(8'($urandom_range(0, 255)), PortId);
        @(negedge aclk);
        s_axis_tdata = 8'h99; s_axis_tdest = PortId; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check_eq("full_tready", s_axis_tready, 0);
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        spi_frame(8'h5A, 8'h00, 8'h00, 8'h00, 1, 1'b1);
        check_eq("tready_after_pop", s_axis_tready, 1);
        for (int i = 0; i < 4; i++) begin
            spi_frame(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48), 4, 1'b1);
        end
        compare_beats();

        // Aborted partial byte, then a full byte.
        @(negedge aclk);
        spi_csn = 1'b0;
        #80;
        void'(model_next());
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'b1; #50; spi_clk = 1'b1; #50; spi_clk = 1'b0;
        end
        #50;
        spi_csn = 1'b1;
        #100;
        spi_frame(8'hF0, 8'h00, 8'h00, 8'h00, 1, 1'b1);
        compare_beats();

        // Randomized traffic.
        for (int it = 0; it < 10; it++) begin
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
                if ($urandom_range(0, 3) != 0) axis_push(8'($urandom_range(0, 255)), PortId);
                else axis_push(8'($urandom_range(0, 255)), PortId + 8'd1 + 8'($urandom_range(0, 200)));
            end
            for (int k = 0; k < 4; k++) r[k] = 8'($urandom_range(0, 255));
            nb = $urandom_range(1, 4);
            spi_frame(r[0], r[1], r[2], r[3], nb, 1'b1);
            compare_beats();
        end

        // Reset mid-byte with stalled output, overflow and queued readback.
        axis_push(8'hC3, PortId);
        axis_push(8'h3D, PortId);
        @(negedge aclk);
        m_axis_tready = 1'b0;
        spi_csn = 1'b0;
        #80;
        spi_byte(8'h12, mi);
        spi_byte(8'h34, mi);
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'b1; #50; spi_clk = 1'b1; #50; spi_clk = 1'b0;
        end
        check_eq("pre_reset_ovf", rx_overflow, 1);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tx_model.delete();
        got_beats.delete();
        exp_beats.delete();
        spi_csn = 1'b1;
        spi_mosi = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        axis_push(8'h42, PortId);
        spi_frame(8'h99, 8'h00, 8'h00, 8'h00, 1, 1'b1);
        compare_beats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
